// File: rtl/ex_div_if.sv
// Handshake between the EX stage and the iterative divider.
// The EX stage drives the master side; the divider sits on the slave side.
interface ex_div_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            hold_req_o;
    logic            busy_o;
    logic            ready_o;
    logic [XLEN-1:0] result_o;
    logic            reg_wen_o;
    logic [4:0]      rd_addr_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
        input  hold_req_o, busy_o, ready_o, result_o, reg_wen_o, rd_addr_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
        output hold_req_o, busy_o, ready_o, result_o, reg_wen_o, rd_addr_o
    );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// One quotient bit per cycle; divide-by-zero and signed overflow finish immediately.
module ex_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic    clk,
    input  logic    rst,
    ex_div_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  ALL_ONES = '1;
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(XLEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q, quo_q, dsr_q;
    logic [1:0]       op_q;
    logic [4:0]       rd_q;
    logic             neg_quo_q, neg_rem_q;
    logic             ready_q;
    logic [XLEN-1:0]  result_q;
    logic [4:0]       rd_out_q;
    logic             hold_req;

    // Operand preparation for an incoming start.
    logic            in_signed, a_neg, b_neg, div_zero, overflow, accept;
    logic [XLEN-1:0] abs_a, abs_b;

    assign in_signed = ~bus.op_i[0];
    assign a_neg     = in_signed & bus.dividend_i[XLEN-1];
    assign b_neg     = in_signed & bus.divisor_i[XLEN-1];
    assign abs_a     = a_neg ? -bus.dividend_i : bus.dividend_i;
    assign abs_b     = b_neg ? -bus.divisor_i  : bus.divisor_i;
    assign div_zero  = (bus.divisor_i == '0);
    assign overflow  = in_signed && (bus.dividend_i == MIN_NEG) && (bus.divisor_i == ALL_ONES);
    assign accept    = (state_q == IDLE) && bus.start_i && !bus.flush_i;

    // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
    logic [XLEN:0]   upper;
    logic            no_borrow;
    logic [XLEN-1:0] rem_nx, quo_nx;

    assign upper     = {rem_q, quo_q[XLEN-1]};
    assign no_borrow = (upper >= {1'b0, dsr_q});
    assign rem_nx    = no_borrow ? (upper[XLEN-1:0] - dsr_q) : upper[XLEN-1:0];
    assign quo_nx    = {quo_q[XLEN-2:0], no_borrow};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        hold_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_req = 1'b1;
                    state_d  = (div_zero || overflow) ? DONE : CALC;
                end
            end
            CALC: begin
                hold_req = 1'b1;
                if (bus.flush_i)             state_d = IDLE;
                else if (cnt_q == LAST_IT)   state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= bus.op_i;
                        rd_q      <= bus.rd_addr_i;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dsr_q     <= abs_b;
                        cnt_q     <= '0;
                        // Fast paths park the final answer straight in quo/rem.
                        if (div_zero) begin
                            quo_q <= ALL_ONES;
                            rem_q <= bus.dividend_i;
                        end else if (overflow) begin
                            quo_q <= MIN_NEG;
                            rem_q <= '0;
                        end else begin
                            quo_q <= abs_a;
                            rem_q <= '0;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IT) begin
                        quo_q <= neg_quo_q ? -quo_nx : quo_nx;
                        rem_q <= neg_rem_q ? -rem_nx : rem_nx;
                    end else begin
                        quo_q <= quo_nx;
                        rem_q <= rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers: a flush arriving in DONE drops the write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            ready_q <= (state_q == DONE) && !bus.flush_i;
            if ((state_q == DONE) && !bus.flush_i) begin
                result_q <= op_q[1] ? rem_q : quo_q;
                rd_out_q <= rd_q;
            end
        end
    end

    assign bus.hold_req_o = hold_req;
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.ready_o    = ready_q;
    assign bus.reg_wen_o  = ready_q;
    assign bus.result_o   = result_q;
    assign bus.rd_addr_o  = rd_out_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, fast paths, signed fixup, flush and async reset.
module tb_ex_div;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ex_div_if #(.XLEN(32)) bus ();

    ex_div #(.XLEN(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one divide at E0 and checks latency, hold window, result and pulse width.
    task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp, input int lat);
        int k;
        int hold_cnt;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.rd_addr_i  = rd;
        #1 check({tag, " hold_in_start_cycle"}, 32'(bus.hold_req_o), 32'd1);
        @(posedge clk);
        k        = -1;
        hold_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start_i    = 1'b0;
            bus.dividend_i = 32'hDEAD_BEEF;
            bus.divisor_i  = 32'h0000_0001;
            #1;
            if (bus.ready_o) begin
                k = i;
                break;
            end
            if (bus.hold_req_o) hold_cnt++;
        end
        check({tag, " ready_edge"}, 32'(k), 32'(lat));
        check({tag, " hold_cycles"}, 32'(hold_cnt), 32'(lat - 1));
        check({tag, " result"}, bus.result_o, exp);
        check({tag, " rd_addr"}, 32'(bus.rd_addr_o), 32'(rd));
        check({tag, " reg_wen"}, 32'(bus.reg_wen_o), 32'd1);
        @(negedge clk);
        #1;
        check({tag, " ready_one_cycle"}, 32'(bus.ready_o), 32'd0);
        check({tag, " result_held"}, bus.result_o, exp);
    endtask

    task automatic start_divu_100_7(input logic [4:0] rd);
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = OP_DIVU;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd7;
        bus.rd_addr_i  = rd;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    initial begin
        int pulses;
        int holds;
        rst            = 1'b0;
        bus.start_i    = 1'b0;
        bus.op_i       = 2'b00;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.rd_addr_i  = '0;
        bus.flush_i    = 1'b0;

        #12;
        check("reset busy",     32'(bus.busy_o),     32'd0);
        check("reset ready",    32'(bus.ready_o),    32'd0);
        check("reset reg_wen",  32'(bus.reg_wen_o),  32'd0);
        check("reset result",   bus.result_o,        32'd0);
        check("reset rd_addr",  32'(bus.rd_addr_o),  32'd0);
        check("reset hold_req", 32'(bus.hold_req_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Normal-latency divides, unsigned and signed.
        run_div("divu_100_7",  OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33);
        run_div("remu_100_7",  OP_REMU, 32'd100,        32'd7,          5'd6,  32'd2,          33);
        run_div("rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF,  33);
        run_div("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFD,  33);
        run_div("div_100_m7",  OP_DIV,  32'd100,        32'hFFFF_FFF9,  5'd9,  32'hFFFF_FFF2,  33);
        run_div("rem_100_m7",  OP_REM,  32'd100,        32'hFFFF_FFF9,  5'd10, 32'd2,          33);

        // Fast paths.
        run_div("divu_5_0",    OP_DIVU, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF,  1);
        run_div("remu_5_0",    OP_REMU, 32'd5,          32'd0,          5'd12, 32'd5,          1);
        run_div("div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  1);
        run_div("rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          1);

        // Flush together with a start in IDLE suppresses acceptance.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = OP_DIVU;
        bus.divisor_i = 32'd3;
        #1 check("idle_flush hold_req", 32'(bus.hold_req_o), 32'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        #1 check("idle_flush busy", 32'(bus.busy_o), 32'd0);

        // Flush at CALC iteration 10 abandons the divide.
        start_divu_100_7(5'd20);
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        check("flush busy",     32'(bus.busy_o),     32'd0);
        check("flush hold_req", 32'(bus.hold_req_o), 32'd0);
        pulses = 0;
        holds  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready_o) pulses++;
            if (bus.hold_req_o) holds++;
        end
        check("flush no_ready", 32'(pulses), 32'd0);
        check("flush no_hold",  32'(holds),  32'd0);
        run_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 33);

        // Asynchronous reset in the middle of CALC.
        start_divu_100_7(5'd22);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst busy",     32'(bus.busy_o),     32'd0);
        check("async_rst ready",    32'(bus.ready_o),    32'd0);
        check("async_rst reg_wen",  32'(bus.reg_wen_o),  32'd0);
        check("async_rst result",   bus.result_o,        32'd0);
        check("async_rst rd_addr",  32'(bus.rd_addr_o),  32'd0);
        check("async_rst hold_req", 32'(bus.hold_req_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready_o) pulses++;
        end
        check("async_rst no_ready", 32'(pulses), 32'd0);
        run_div("remu_1000_7", OP_REMU, 32'd1000, 32'd7, 5'd23, 32'd6, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions, located in the EX stage.
- Consumes operands that EX receives from the ID/EX pipeline register.
- Drives the hold request back to ctrl, which freezes ID/EX and the earlier stages while a divide is in progress.
- Radix-2 restoring algorithm: one quotient bit per cycle, with fast paths for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand and result width
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = XLEN

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start_i  in  1  EX has a valid divide instruction this cycle
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  in  XLEN  rs1 value (op1)
- divisor_i  in  XLEN  rs2 value (op2)
- rd_addr_i  in  5  destination register
- flush_i  in  1  jump/flush from ctrl; kills any in-flight divide
- hold_req_o  out  1  to ctrl; request a pipeline hold
- busy_o  out  1  state is not IDLE
- ready_o  out  1  one-cycle result-valid pulse
- result_o  out  XLEN  quotient or remainder
- reg_wen_o  out  1  write enable to WB; equals ready_o
- rd_addr_o  out  5  destination register, latched at start

Behaviour:
- Reset:
  - clk and rst are the only clock and reset; rst is asynchronous, active-low.
  - While rst=0: state=IDLE; counter, remainder, quotient, latched op and latched rd all 0.
  - Outputs held at 0: ready_o, reg_wen_o, busy_o, result_o, rd_addr_o.
  - Reset asserted mid-operation abandons the divide; no ready_o pulse follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - A start is accepted when start_i=1 and flush_i=0.
  - On acceptance, latch op, rd and the sign flags; load abs(dividend) and abs(divisor). Abs is taken only for DIV/REM; DIVU/REMU load the raw values.
  - Divisor=0: go to DONE. Result is 0xFFFFFFFF for DIV/DIVU, dividend_i for REM/REMU.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: go to DONE. Result is 0x80000000 for DIV, 0 for REM.
  - Otherwise go to CALC with counter=0.
- CALC:
  - Each cycle, shift {rem, dividend} left by 1 and trial-subtract the divisor from the upper half.
  - If the subtraction does not borrow, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - The counter increments each cycle; after the iteration with counter=31, go to DONE.
  - Sign fixup is computed when entering DONE:
    - The quotient is negated if the operand signs differed (signed ops only).
    - The remainder is negated if the dividend was negative (signed ops only).
- DONE: lasts one cycle with ready_o=reg_wen_o=1 and result_o/rd_addr_o valid, then returns to IDLE.
- Outputs are registered; result_o and rd_addr_o hold their values after DONE until the next completion.
- Latency, taking edge E0 as the one that samples the accepted start:
  - Normal divide: ready_o is high between E33 and E34.
  - Fast path: ready_o is high between E1 and E2.
- hold_req_o is combinational:
  - 1 in IDLE when start_i=1 and flush_i=0, so ctrl holds ID/EX in the same cycle as the start.
  - 1 throughout CALC.
  - 0 in DONE, so the next instruction advances while the result is written back.
- busy_o = 1 whenever the state is not IDLE.
- flush_i:
  - In CALC or DONE: next state is IDLE; ready_o and reg_wen_o are forced to 0 in that cycle; no result is produced.
  - In IDLE: suppresses acceptance of a start arriving in the same cycle.
- start_i while in CALC or DONE is ignored; operands are never re-latched mid-operation.
- A start presented in the cycle immediately after DONE (state IDLE) is accepted normally, so back-to-back divides work.

Test Plan:
- DIVU 100/7, start at E0 → hold_req_o=1 from the start cycle through CALC; ready_o pulse between E33 and E34; result_o=14; rd_addr_o equals the latched rd; reg_wen_o=1 for exactly one cycle.
- REM 0xFFFFFFF9 (-7) / 2, then DIV with the same operands → REM gives 0xFFFFFFFF (-1); DIV gives 0xFFFFFFFD (-3); both at 33-cycle latency.
- DIVU 5/0 and REMU 5/0 → ready_o between E1 and E2; results 0xFFFFFFFF and 0x00000005; hold_req_o high only in the start cycle.
- DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000 with 1-cycle latency; REM with the same operands → 0.
- flush_i asserted at CALC iteration 10 → state IDLE next cycle; no ready_o pulse; hold_req_o=0 from that cycle onward; a fresh DIVU 9/3 afterwards returns 3.
- rst driven low asynchronously mid-CALC → all outputs 0 immediately without waiting for a clock edge; no ready_o pulse after release; the next start behaves normally.
